// File: rtl/spi_adc_pkg.sv
// ============================================================================
// Module  : spi_adc_pkg
// Purpose : Shared FSM states, SPI mode constants and channel-width helper.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Mode 0: CPOL in bit 1, CPHA in bit 0.
    localparam logic [1:0] SPI_MODE = 2'd0;
    localparam logic       SCK_IDLE = SPI_MODE[1];

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sck_tick.sv
// ============================================================================
// Module  : spi_sck_tick
// Purpose : Half-period timer; strobes every HALF cycles with rise/fall phase.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_sck_tick #(
    parameter int HALF = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic half_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          half_end;

    assign half_end = en_i && (cnt_q == CW'(HALF - 1));

    // phase_q low means the current half-period is an SCK-low half.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (half_end) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign half_o = half_end;
    assign rise_o = half_end && !phase_q;
    assign fall_o = half_end &&  phase_q;

endmodule

`default_nettype wire

// File: rtl/spi_adc_scan_master.sv
// ============================================================================
// Module  : spi_adc_scan_master
// Purpose : Mode-0 SPI master for multi-channel ADCs; optional auto-scan
//           selected by macro SPI_ADC_AUTOSCAN_EN (adds SCAN_EN input).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_adc_scan_master
    import spi_adc_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4,
    parameter int NUM_CH  = 4,
    parameter int CS_GAP  = 2,
    parameter int CH_W    = ch_width(NUM_CH)
) (
    input  logic              SYS_CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [CH_W-1:0]   CH_SEL,
    input  logic [DATA_W-1:0] DATA_MOSI,
    input  logic              MISO,
`ifdef SPI_ADC_AUTOSCAN_EN
    input  logic              SCAN_EN,
`endif
    output logic              MOSI,
    output logic              SCK,
    output logic [NUM_CH-1:0] CSbar,
    output logic              BUSY,
    output logic              FIN,
    output logic [DATA_W-1:0] DATA_MISO,
    output logic [CH_W-1:0]   CH_OUT
);

    localparam int              H      = CLK_DIV / 2;
    localparam int              CNT_W  = 16;
    localparam logic [CH_W:0]   CH_LIM = (CH_W + 1)'(NUM_CH);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    half_q, half_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic [NUM_CH-1:0]   cs_q, cs_d;
    logic                fin_q, fin_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [CH_W-1:0]     chout_q, chout_d;

    logic                tick_half, tick_rise, tick_fall;
    logic                req;
    logic [CH_W-1:0]     req_ch;

    spi_sck_tick #(
        .HALF (H)
    ) u_tick (
        .clk_i  (SYS_CLK),
        .rst_i  (RST),
        .en_i   (state_q != ST_IDLE),
        .half_o (tick_half),
        .rise_o (tick_rise),
        .fall_o (tick_fall)
    );

`ifdef SPI_ADC_AUTOSCAN_EN
    logic [CH_W-1:0] scan_ch_q, scan_ch_d;

    // While SCAN_EN is held the channel advances on every accept; dropping it
    // in IDLE rewinds the scan to channel 0.
    always_comb begin
        scan_ch_d = scan_ch_q;
        if (state_q == ST_IDLE) begin
            if (!SCAN_EN)
                scan_ch_d = '0;
            else if (scan_ch_q == CH_W'(NUM_CH - 1))
                scan_ch_d = '0;
            else
                scan_ch_d = scan_ch_q + CH_W'(1);
        end
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) scan_ch_q <= '0;
        else     scan_ch_q <= scan_ch_d;
    end

    assign req    = SCAN_EN || (START && ({1'b0, CH_SEL} < CH_LIM));
    assign req_ch = SCAN_EN ? scan_ch_q : CH_SEL;
`else
    assign req    = START && ({1'b0, CH_SEL} < CH_LIM);
    assign req_ch = CH_SEL;
`endif

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        ch_d    = ch_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        fin_d   = 1'b0;
        dout_d  = dout_q;
        chout_d = chout_q;

        case (state_q)
            ST_IDLE: begin
                sck_d  = SCK_IDLE;
                mosi_d = 1'b0;
                cs_d   = '1;
                if (req) begin
                    state_d = ST_SETUP;
                    half_d  = '0;
                    tx_d    = DATA_MOSI;
                    ch_d    = req_ch;
                    cs_d    = ~(NUM_CH'(1) << req_ch);
                    mosi_d  = DATA_MOSI[DATA_W-1];
                end
            end
            ST_SETUP: begin
                if (tick_rise) begin
                    state_d = ST_XFER;
                    half_d  = '0;
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[DATA_W-2:0], MISO};
                end
            end
            ST_XFER: begin
                // Even halves are SCK-high, odd halves SCK-low; the final low
                // half flows straight into HOLD without another rise.
                if (tick_half) begin
                    if (half_q == CNT_W'(2 * DATA_W - 1)) begin
                        state_d = ST_HOLD;
                        half_d  = '0;
                    end else begin
                        half_d = half_q + CNT_W'(1);
                        if (tick_fall) begin
                            sck_d  = 1'b0;
                            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                            mosi_d = tx_q[DATA_W-2];
                        end else if (tick_rise) begin
                            sck_d = 1'b1;
                            rx_d  = {rx_q[DATA_W-2:0], MISO};
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick_half) begin
                    state_d = ST_GAP;
                    half_d  = '0;
                    cs_d    = '1;
                    mosi_d  = 1'b0;
                    fin_d   = 1'b1;
                    dout_d  = rx_q;
                    chout_d = ch_q;
                end
            end
            ST_GAP: begin
                if (tick_half) begin
                    if (half_q == CNT_W'(CS_GAP - 1)) begin
                        state_d = ST_IDLE;
                        half_d  = '0;
                    end else begin
                        half_d = half_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sck_d   = SCK_IDLE;
                mosi_d  = 1'b0;
                cs_d    = '1;
            end
        endcase
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            half_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            ch_q    <= '0;
            sck_q   <= SCK_IDLE;
            mosi_q  <= 1'b0;
            cs_q    <= '1;
            fin_q   <= 1'b0;
            dout_q  <= '0;
            chout_q <= '0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            ch_q    <= ch_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            fin_q   <= fin_d;
            dout_q  <= dout_d;
            chout_q <= chout_d;
        end
    end

    assign MOSI      = mosi_q;
    assign SCK       = sck_q;
    assign CSbar     = cs_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign FIN       = fin_q;
    assign DATA_MISO = dout_q;
    assign CH_OUT    = chout_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_adc_scan_master.sv
// ============================================================================
// Module  : tb_spi_adc_scan_master
// Purpose : Directed bench for spi_adc_scan_master (default and 12-bit/1-ch
//           builds; auto-scan steps when SPI_ADC_AUTOSCAN_EN is defined).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_adc_scan_master;

    logic        clk;
    logic        rst, start, miso, mosi, sck, busy, fin;
    logic [1:0]  ch_sel, ch_out;
    logic [15:0] data_mosi, data_miso;
    logic [3:0]  csbar;

    logic        rst2, start2, miso2, mosi2, sck2, busy2, fin2;
    logic [0:0]  ch_sel2, chout2, csbar2;
    logic [11:0] data2, dmiso2;

`ifdef SPI_ADC_AUTOSCAN_EN
    logic        scan_en, scan_en2;
    logic [1:0]  fin_ch [5];
    int          fin_n  [5];
    int          k;
`endif

    int          total = 0;
    int          bad   = 0;

    logic [15:0] slave_word, slave_sh;
    logic [11:0] slave2_word, slave2_sh;
    logic        s_prev, s2_prev;

    int          n_rise, fin_cnt, fin_at, fin_first, cs_bad;
    logic [15:0] mosi_bits;
    logic [11:0] mosi_bits2;
    logic        prev_sck;

    spi_adc_scan_master u_dut (
        .SYS_CLK   (clk),
        .RST       (rst),
        .START     (start),
        .CH_SEL    (ch_sel),
        .DATA_MOSI (data_mosi),
        .MISO      (miso),
`ifdef SPI_ADC_AUTOSCAN_EN
        .SCAN_EN   (scan_en),
`endif
        .MOSI      (mosi),
        .SCK       (sck),
        .CSbar     (csbar),
        .BUSY      (busy),
        .FIN       (fin),
        .DATA_MISO (data_miso),
        .CH_OUT    (ch_out)
    );

    spi_adc_scan_master #(
        .DATA_W  (12),
        .CLK_DIV (2),
        .NUM_CH  (1)
    ) u_dut2 (
        .SYS_CLK   (clk),
        .RST       (rst2),
        .START     (start2),
        .CH_SEL    (ch_sel2),
        .DATA_MOSI (data2),
        .MISO      (miso2),
`ifdef SPI_ADC_AUTOSCAN_EN
        .SCAN_EN   (scan_en2),
`endif
        .MOSI      (mosi2),
        .SCK       (sck2),
        .CSbar     (csbar2),
        .BUSY      (busy2),
        .FIN       (fin2),
        .DATA_MISO (dmiso2),
        .CH_OUT    (chout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode-0 ADC models: MSB ready once CS drops, next bit after each SCK fall.
    always @(negedge clk) begin
        if (csbar === 4'hF) begin
            slave_sh = slave_word;
        end else if (s_prev && !sck) begin
            slave_sh = slave_sh << 1;
        end
        s_prev = sck;
        miso   = slave_sh[15];
    end

    always @(negedge clk) begin
        if (csbar2 === 1'b1) begin
            slave2_sh = slave2_word;
        end else if (s2_prev && !sck2) begin
            slave2_sh = slave2_sh << 1;
        end
        s2_prev = sck2;
        miso2   = slave2_sh[11];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ch_sel = '0; data_mosi = '0;
        rst2 = 1'b1; start2 = 1'b0; ch_sel2 = '0; data2 = '0;
        slave_word = '0; slave2_word = '0; s_prev = 1'b0; s2_prev = 1'b0;
`ifdef SPI_ADC_AUTOSCAN_EN
        scan_en = 1'b0; scan_en2 = 1'b0;
`endif
        repeat (3) tick();

        check("rst_csbar", csbar, 4'hF);
        check("rst_sck", sck, 1'b0);
        check("rst_busy_fin", {busy, fin, mosi}, 3'b000);
        check("rst_dout", {ch_out, data_miso}, 18'h0);

        rst = 1'b0;
        tick(); tick();

        // Frame 1: ch 2, command A5C3, ADC answers 1234; stray START at 30.
        start = 1'b1; ch_sel = 2'd2; data_mosi = 16'hA5C3; slave_word = 16'h1234;
        n_rise = 0; mosi_bits = '0; fin_cnt = 0; fin_at = -1; cs_bad = 0; prev_sck = 1'b0;
        check("cs_c0", csbar, 4'hF);
        for (int n = 1; n <= 76; n++) begin
            tick();
            if (n == 1)  start = 1'b0;
            if (n == 30) start = 1'b1;
            if (n == 31) start = 1'b0;
            if (sck && !prev_sck) begin
                n_rise++;
                mosi_bits = {mosi_bits[14:0], mosi};
            end
            prev_sck = sck;
            if (fin) begin fin_cnt++; fin_at = n; end
            if (csbar !== ((n <= 68) ? 4'b1011 : 4'b1111)) cs_bad++;
            if (n == 69) begin
                check("f1_dout", data_miso, 16'h1234);
                check("f1_chout", ch_out, 2'd2);
            end
            if (n == 70) check("f1_idle_lines", {sck, mosi}, 2'b00);
            if (n == 72) check("f1_busy_c72", busy, 1'b1);
            if (n == 73) check("f1_busy_c73", busy, 1'b0);
        end
        check("f1_cs_window", cs_bad, 0);
        check("f1_sck_rises", n_rise, 16);
        check("f1_mosi_bits", mosi_bits, 16'hA5C3);
        check("f1_fin_count", fin_cnt, 1);
        check("f1_fin_cycle", fin_at, 69);
        check("f1_dout_hold", {ch_out, data_miso}, {2'd2, 16'h1234});

        // Reset in the middle of XFER.
        start = 1'b1; ch_sel = 2'd0; data_mosi = 16'hFFFF; slave_word = 16'hFFFF;
        fin_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (fin) fin_cnt++;
        end
        check("ab_cs_active", csbar, 4'b1110);
        check("ab_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("ab_csbar", csbar, 4'hF);
        check("ab_sck_mosi", {sck, mosi}, 2'b00);
        check("ab_busy_fin", {busy, fin}, 2'b00);
        check("ab_dout", {ch_out, data_miso}, 18'h0);
        tick();
        rst = 1'b0;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (fin) fin_cnt++;
        end
        check("ab_no_fin", fin_cnt, 0);
        check("ab_dout_after", data_miso, 16'h0);

        // START held high: back-to-back frames on ch 1.
        start = 1'b1; ch_sel = 2'd1; data_mosi = 16'h0F0F; slave_word = 16'hBEEF;
        fin_cnt = 0; fin_at = -1; fin_first = -1;
        for (int n = 1; n <= 160; n++) begin
            tick();
            if (n == 140) start = 1'b0;
            if (fin) begin
                fin_cnt++;
                if (fin_first < 0) fin_first = n;
                else               fin_at = n;
            end
            if (n == 1)  check("bb_cs_c1", csbar, 4'b1101);
            if (n == 73) check("bb_idle_c73", {busy, csbar}, 5'b01111);
            if (n == 74) check("bb_cs_c74", csbar, 4'b1101);
        end
        check("bb_fin_count", fin_cnt, 2);
        check("bb_fin_first", fin_first, 69);
        check("bb_fin_spacing", fin_at - fin_first, 73);
        check("bb_dout", {ch_out, data_miso}, {2'd1, 16'hBEEF});
        check("bb_busy_end", busy, 1'b0);

`ifdef SPI_ADC_AUTOSCAN_EN
        // Auto-scan for five frames, then drop SCAN_EN.
        slave_word = 16'h5A5A; data_mosi = 16'h8001; k = 0;
        scan_en = 1'b1;
        for (int n = 1; n <= 380; n++) begin
            tick();
            if (fin) begin
                if (k < 5) begin
                    fin_ch[k] = ch_out;
                    fin_n[k]  = n;
                end
                k++;
                if (k == 5) scan_en = 1'b0;
            end
        end
        check("sc_fin_count", k, 5);
        check("sc_ch_seq", {fin_ch[0], fin_ch[1], fin_ch[2], fin_ch[3], fin_ch[4]}, 10'b00_01_10_11_00);
        check("sc_space_1", fin_n[1] - fin_n[0], 73);
        check("sc_space_4", fin_n[4] - fin_n[3], 73);
        check("sc_dout", data_miso, 16'h5A5A);
        check("sc_busy_end", busy, 1'b0);
`endif

        // 12-bit, divide-by-2, single-channel instance.
        rst2 = 1'b0;
        tick();
        start2 = 1'b1; ch_sel2 = 1'b1;
        cs_bad = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 1) start2 = 1'b0;
            if (busy2 || (csbar2 !== 1'b1) || fin2) cs_bad++;
        end
        check("s_bad_ch_ignored", cs_bad, 0);

        start2 = 1'b1; ch_sel2 = 1'b0; data2 = 12'h3A5; slave2_word = 12'h9C6;
        n_rise = 0; mosi_bits2 = '0; fin_cnt = 0; fin_at = -1; prev_sck = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            tick();
            if (n == 1) start2 = 1'b0;
            if (sck2 && !prev_sck) begin
                n_rise++;
                mosi_bits2 = {mosi_bits2[10:0], mosi2};
            end
            prev_sck = sck2;
            if (fin2) begin fin_cnt++; fin_at = n; end
            if (n == 1)  check("s_cs_c1", csbar2, 1'b0);
            if (n == 27) check("s_cs_c27", csbar2, 1'b1);
            if (n == 28) check("s_busy_c28", busy2, 1'b1);
            if (n == 29) check("s_busy_c29", busy2, 1'b0);
        end
        check("s_sck_rises", n_rise, 12);
        check("s_mosi_bits", mosi_bits2, 12'h3A5);
        check("s_fin", {fin_cnt[7:0], fin_at[7:0]}, {8'd1, 8'd27});
        check("s_dout", {chout2, dmiso2}, {1'b0, 12'h9C6});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
